pool_relu_stream: RTL

POOL_RELU_STREAM -- requirements
Module: pool_relu_stream

---
 rtl/pool_relu_stream.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pool_relu_stream.sv
// pool_relu_stream
//   Streaming 2x2 / stride-2 pooling followed by ReLU, CH channels in lockstep.
//   Pixels arrive row-major, one per iValid cycle. Even rows build per-column-pair
//   horizontal partials in a line buffer; odd rows complete the window and emit a
//   registered result exactly one cycle after the completing pixel is accepted.
//
//   Build option: define POOL_RELU_AVG_EN to include the average-pooling datapath
//   (selected by iMode, latched at frame start). Without it, max pooling is always
//   used and iMode is ignored.
//
// Ports
//   iClk    in   clock, rising edge
//   iRsn    in   asynchronous active-low reset
//   iValid  in   pixel present this cycle
//   iSof    in   start of frame (qualified by iValid)
//   iMode   in   0 = max, 1 = average (only with POOL_RELU_AVG_EN)
//   iData   in   CH packed signed samples, channel c at [c*DW +: DW]
//   oValid  out  pooled pixel present this cycle
//   oData   out  CH packed pooled/ReLU'd samples, held when oValid=0
//   oEof    out  last pooled pixel of the frame
//   oErr    out  one-cycle pulse on iSof arriving mid-frame
module pool_relu_stream #(
  parameter int CH = 4,
  parameter int DW = 32,
  parameter int W  = 26,
  parameter int H  = 6
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iValid,
  input  logic             iSof,
  input  logic             iMode,
  input  logic [CH*DW-1:0] iData,
  output logic             oValid,
  output logic [CH*DW-1:0] oData,
  output logic             oEof,
  output logic             oErr
);

  localparam int NPW = W / 2;
  localparam int NPH = H / 2;
  localparam int CW  = $clog2(W);
  localparam int RW  = $clog2(H);
  localparam int LIW = (NPW > 1) ? $clog2(NPW) : 1;
`ifdef POOL_RELU_AVG_EN
  localparam int PW  = DW + 1;  // horizontal sum needs one extra bit
`else
  localparam int PW  = DW;
`endif

  localparam logic [CW-1:0] COL_LAST     = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(H - 1);
  localparam logic [CW-1:0] COL_OUT_LAST = CW'(2 * NPW - 1);
  localparam logic [RW-1:0] ROW_OUT_LAST = RW'(2 * NPH - 1);

  logic [CW-1:0]    col_q, col_d, pos_col;
  logic [RW-1:0]    row_q, row_d, pos_row;
  logic [CH*DW-1:0] hold_q, hold_d;
  logic [CH*PW-1:0] lb_q [NPW];
  logic [CH*PW-1:0] lb_rd;
  logic [CH*PW-1:0] hpart_all;
  logic [CH*DW-1:0] res_all;
  logic [LIW-1:0]   lb_idx;
  logic             is_sof, mid_sof, fire, out_fire, lb_we, last_out;
  logic             oValid_q, oEof_q, oErr_q;
  logic [CH*DW-1:0] oData_q;

  // A start-of-frame pixel is always handled as (0,0), wherever the counters were.
  assign is_sof  = iValid & iSof;
  assign mid_sof = is_sof & ((col_q != '0) | (row_q != '0));
  assign pos_col = is_sof ? '0 : col_q;
  assign pos_row = is_sof ? '0 : row_q;

  // Odd columns complete a horizontal pair; odd rows complete the window.
  // With odd W/H the trailing column/row is even, so it never fires.
  assign fire     = iValid & pos_col[0];
  assign out_fire = fire & pos_row[0];
  assign lb_we    = fire & ~pos_row[0];
  assign last_out = (pos_col == COL_OUT_LAST) & (pos_row == ROW_OUT_LAST);
  assign lb_idx   = LIW'(pos_col >> 1);
  assign lb_rd    = lb_q[lb_idx];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    if (iValid) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      if (!pos_col[0]) hold_d = iData;
    end
  end

`ifdef POOL_RELU_AVG_EN
  logic mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (iValid && pos_col == '0 && pos_row == '0) mode_d = iMode;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) mode_q <= 1'b0;
    else       mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = iMode;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] cur_s, hld_s, hmax_s, lbl_s, vmax_s, res_s;

    assign cur_s  = iData[c*DW +: DW];
    assign hld_s  = hold_q[c*DW +: DW];
    assign hmax_s = (cur_s > hld_s) ? cur_s : hld_s;

`ifdef POOL_RELU_AVG_EN
    logic signed [DW:0]   hsum_s, hpart_s, lbv_s;
    logic signed [DW-1:0] hlo_s;
    logic signed [DW+1:0] vsum_s;
    logic [1:0]           unused_lsb;

    assign hsum_s  = {cur_s[DW-1], cur_s} + {hld_s[DW-1], hld_s};
    // In max mode the partial is the sign-extended max, so its low DW bits are exact.
    assign hpart_s = mode_q ? hsum_s : {hmax_s[DW-1], hmax_s};
    assign lbv_s   = lb_rd[c*PW +: PW];
    assign hlo_s   = hpart_s[DW-1:0];
    assign lbl_s   = lbv_s[DW-1:0];
    assign vmax_s  = (hlo_s > lbl_s) ? hlo_s : lbl_s;
    assign vsum_s  = {hpart_s[DW], hpart_s} + {lbv_s[DW], lbv_s};
    // Dropping the two LSBs of the signed sum is a floor divide by 4, truncated to DW.
    assign res_s      = mode_q ? vsum_s[DW+1:2] : vmax_s;
    assign unused_lsb = vsum_s[1:0];
    assign hpart_all[c*PW +: PW] = hpart_s;
`else
    assign lbl_s  = lb_rd[c*PW +: PW];
    assign vmax_s = (hmax_s > lbl_s) ? hmax_s : lbl_s;
    assign res_s  = vmax_s;
    assign hpart_all[c*PW +: PW] = hmax_s;
`endif

    assign res_all[c*DW +: DW] = res_s[DW-1] ? '0 : res_s;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      col_q    <= '0;
      row_q    <= '0;
      hold_q   <= '0;
      oValid_q <= 1'b0;
      oEof_q   <= 1'b0;
      oErr_q   <= 1'b0;
      oData_q  <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      hold_q   <= hold_d;
      oValid_q <= out_fire;
      oEof_q   <= out_fire & last_out;
      oErr_q   <= mid_sof;
      if (out_fire) oData_q <= res_all;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge iClk) begin
    if (lb_we) lb_q[lb_idx] <= hpart_all;
  end

  assign oValid = oValid_q;
  assign oEof   = oEof_q;
  assign oErr   = oErr_q;
  assign oData  = oData_q;

endmodule
